// File: rtl/sprite_pkg.sv
// Shared constants and FSM state type for the sprite ROM row fetcher.
package sprite_pkg;

  localparam int SPRITE_ADDR_W        = 7;
  localparam int SPRITE_DATA_W        = 16;
  localparam int SPRITE_WORDS_PER_ROW = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/sprite_fifo.sv
// Synchronous FIFO with flush; push and pop in the same cycle are allowed even when full.
module sprite_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 17,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == CNT_W'(DEPTH));
  assign empty = (count_r == CNT_W'(0));

endmodule

// File: rtl/sprite_rom_row_fetcher.sv
// Avalon-MM read master fetching one sprite row from ROM into a valid/ready pixel stream.
// row carries one extra bit so that out-of-range requests are representable and flagged on err.
module sprite_rom_row_fetcher
  import sprite_pkg::*;
#(
  parameter int ADDR_W        = SPRITE_ADDR_W,
  parameter int DATA_W        = SPRITE_DATA_W,
  parameter int WORDS_PER_ROW = SPRITE_WORDS_PER_ROW,
  parameter int ROWS          = (2 ** ADDR_W) / WORDS_PER_ROW,
  parameter int FIFO_DEPTH    = 4,
  parameter int ROW_W         = $clog2(ROWS) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ROW_W-1:0]  row,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] rom_address,
  output logic              rom_chipselect,
  output logic              rom_write,
  output logic [1:0]        rom_byteenable,
  output logic              rom_clken,
  input  logic [DATA_W-1:0] rom_readdata,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_last
);

  localparam int CNT_W  = $clog2(WORDS_PER_ROW) + 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W  = FCNT_W + 1;

  localparam logic [CNT_W-1:0] WPR_L   = CNT_W'(WORDS_PER_ROW);
  localparam logic [CNT_W-1:0] LAST_L  = CNT_W'(WORDS_PER_ROW - 1);
  localparam logic [ROW_W-1:0] ROWS_L  = ROW_W'(ROWS);
  localparam logic [OCC_W-1:0] DEPTH_L = OCC_W'(FIFO_DEPTH);

  fetch_state_t      state_r;
  logic [ADDR_W-1:0] base_r;
  logic [CNT_W-1:0]  issue_cnt_r;
  logic [CNT_W-1:0]  ret_cnt_r;
  logic [ADDR_W-1:0] rom_address_r;
  logic              rom_chipselect_r;
  logic              inflight_r;
  logic              busy_r;
  logic              done_r;
  logic              err_r;

  logic              issue_s;
  logic [OCC_W-1:0]  occupancy_s;
  logic              push_s;
  logic              pop_s;
  logic              last_pop_s;
  logic [DATA_W:0]   fifo_head_s;
  logic [FCNT_W-1:0] fifo_count_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;

  assign push_s     = inflight_r && (state_r == FETCH);
  assign pop_s      = pix_ready && !fifo_empty_s;
  assign last_pop_s = pop_s && fifo_head_s[0];

  // Issue gate: never commit more reads than the FIFO can still absorb.
  always_comb begin
    occupancy_s = {1'b0, fifo_count_s}
                + {{FCNT_W{1'b0}}, rom_chipselect_r}
                + {{FCNT_W{1'b0}}, inflight_r};
    if ((state_r == FETCH) && (issue_cnt_r < WPR_L) && !fifo_full_s && (occupancy_s < DEPTH_L)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // Fetch FSM, ROM request pipeline and status pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r          <= IDLE;
      base_r           <= '0;
      issue_cnt_r      <= '0;
      ret_cnt_r        <= '0;
      rom_address_r    <= '0;
      rom_chipselect_r <= 1'b0;
      inflight_r       <= 1'b0;
      busy_r           <= 1'b0;
      done_r           <= 1'b0;
      err_r            <= 1'b0;
    end else if (abort) begin
      state_r          <= IDLE;
      issue_cnt_r      <= '0;
      ret_cnt_r        <= '0;
      rom_chipselect_r <= 1'b0;
      inflight_r       <= 1'b0;
      busy_r           <= 1'b0;
      done_r           <= 1'b0;
      err_r            <= 1'b0;
    end else begin
      done_r           <= 1'b0;
      err_r            <= 1'b0;
      rom_chipselect_r <= issue_s;
      inflight_r       <= rom_chipselect_r;
      if (issue_s) begin
        rom_address_r <= base_r + ADDR_W'(issue_cnt_r);
        issue_cnt_r   <= issue_cnt_r + CNT_W'(1);
      end
      case (state_r)
        IDLE: begin
          if (start && (row < ROWS_L)) begin
            base_r      <= ADDR_W'(row * WORDS_PER_ROW);
            issue_cnt_r <= '0;
            ret_cnt_r   <= '0;
            busy_r      <= 1'b1;
            state_r     <= FETCH;
          end else if (start) begin
            err_r <= 1'b1;
          end
        end
        FETCH: begin
          if (push_s) begin
            ret_cnt_r <= ret_cnt_r + CNT_W'(1);
            if (ret_cnt_r == LAST_L) begin
              state_r <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (last_pop_s) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  sprite_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W + 1)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (abort),
    .push      (push_s),
    .push_data ({rom_readdata, (ret_cnt_r == LAST_L)}),
    .pop       (pop_s),
    .head      (fifo_head_s),
    .count     (fifo_count_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  assign busy           = busy_r;
  assign done           = done_r;
  assign err            = err_r;
  assign rom_address    = rom_address_r;
  assign rom_chipselect = rom_chipselect_r;
  assign rom_write      = 1'b0;
  assign rom_byteenable = 2'b11;
  assign rom_clken      = 1'b1;
  assign pix_valid      = !fifo_empty_s;
  assign pix_data       = fifo_head_s[DATA_W:1];
  assign pix_last       = fifo_head_s[0];

endmodule

// File: tb/tb_sprite_rom_row_fetcher.sv
// Scoreboard bench: directed rows against a ROM whose word at address a is 16'hA000+a.
module tb_sprite_rom_row_fetcher;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  row = 5'd0;
  logic        abort = 1'b0;
  logic        busy, done, err;
  logic [6:0]  rom_address;
  logic        rom_chipselect, rom_write, rom_clken;
  logic [1:0]  rom_byteenable;
  logic [15:0] rom_q = 16'h0000;
  logic        pix_valid;
  logic        pix_ready = 1'b0;
  logic [15:0] pix_data;
  logic        pix_last;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int cs_cnt   = 0;
  logic [16:0] exp_q [$];
  int          addr_log [$];
  int          xfer_cyc [$];

  sprite_rom_row_fetcher dut (
    .clk(clk), .reset_n(reset_n), .start(start), .row(row), .abort(abort),
    .busy(busy), .done(done), .err(err),
    .rom_address(rom_address), .rom_chipselect(rom_chipselect), .rom_write(rom_write),
    .rom_byteenable(rom_byteenable), .rom_clken(rom_clken), .rom_readdata(rom_q),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_last(pix_last)
  );

  always #5 clk = ~clk;

  // ROM model: registered address, q valid the cycle after the address.
  always @(posedge clk) begin
    rom_q <= 16'hA000 + {9'd0, rom_address};
    cyc   <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every pixel transfer and logs ROM traffic.
  always @(negedge clk) begin
    if (reset_n) begin
      if (pix_valid && pix_ready) begin
        xfer_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_pixel", {15'd0, pix_data, pix_last}, 32'hFFFFFFFF);
        end else begin
          check("pixel", {15'd0, pix_data, pix_last}, {15'd0, exp_q.pop_front()});
        end
      end
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (rom_chipselect) begin
        cs_cnt++;
        addr_log.push_back(int'(rom_address));
      end
    end
  end

  task automatic push_row(input int r);
    logic [15:0] d;
    for (int i = 0; i < 8; i++) begin
      d = 16'hA000 + 16'(r * 8 + i);
      exp_q.push_back({d, (i == 7) ? 1'b1 : 1'b0});
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [4:0] r);
    @(posedge clk); #1;
    start = 1'b1;
    row   = r;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int k;
    k = 0;
    while (busy && k < max_cyc) begin
      step(1);
      k++;
    end
    if (busy) check({name, "_timeout"}, 32'd1, 32'd0);
    step(2);
  endtask

  initial begin
    int d0, c0, e0;
    // Reset state.
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_be", {30'd0, rom_byteenable}, 32'd3);
    step(3);
    reset_n = 1'b1;
    step(1);
    check("rst_outs", {busy, done, err, rom_chipselect, rom_write, pix_valid, pix_last}, 32'd0);
    check("rst_addr_data", {9'd0, rom_address, pix_data}, 32'd0);
    check("rst_clken", {31'd0, rom_clken}, 32'd1);

    // Row 3 with free-flowing consumer.
    pix_ready = 1'b1;
    push_row(3);
    d0 = done_cnt;
    xfer_cyc.delete();
    do_start(5'd3);
    check("busy_on_start", {31'd0, busy}, 32'd1);
    wait_idle("row3", 60);
    check("row3_done", done_cnt - d0, 32'd1);
    check("row3_drained", exp_q.size(), 32'd0);
    check("row3_back_to_back", xfer_cyc[7] - xfer_cyc[0], 32'd7);
    check("row3_busy_low", {31'd0, busy}, 32'd0);

    // Row 0 with consumer stalled: exactly FIFO_DEPTH reads.
    pix_ready = 1'b0;
    push_row(0);
    c0 = cs_cnt;
    do_start(5'd0);
    step(20);
    check("stall_reads", cs_cnt - c0, 32'd4);
    check("stall_valid", {31'd0, pix_valid}, 32'd1);
    check("stall_none_popped", exp_q.size(), 32'd8);
    pix_ready = 1'b1;
    wait_idle("row0", 60);
    check("row0_drained", exp_q.size(), 32'd0);
    check("row0_reads", cs_cnt - c0, 32'd8);

    // Row 15 with random backpressure.
    push_row(15);
    addr_log.delete();
    d0 = done_cnt;
    do_start(5'd15);
    for (int k = 0; k < 400 && busy; k++) begin
      pix_ready = 1'($urandom_range(0, 1));
      step(1);
    end
    pix_ready = 1'b1;
    wait_idle("row15", 60);
    check("row15_drained", exp_q.size(), 32'd0);
    check("row15_nreads", addr_log.size(), 32'd8);
    for (int i = 0; i < 8 && i < addr_log.size(); i++) begin
      check("row15_addr", addr_log[i], 32'(120 + i));
    end
    check("row15_done", done_cnt - d0, 32'd1);

    // Out-of-range row.
    c0 = cs_cnt;
    e0 = err_cnt;
    do_start(5'd16);
    check("bad_row_busy", {31'd0, busy}, 32'd0);
    step(5);
    check("bad_row_err", err_cnt - e0, 32'd1);
    check("bad_row_no_cs", cs_cnt - c0, 32'd0);

    // Start while busy is ignored.
    push_row(4);
    d0 = done_cnt;
    e0 = err_cnt;
    do_start(5'd4);
    step(2);
    do_start(5'd7);
    wait_idle("row4", 60);
    check("busy_start_drained", exp_q.size(), 32'd0);
    check("busy_start_done", done_cnt - d0, 32'd1);
    check("busy_start_no_err", err_cnt - e0, 32'd0);

    // Abort after 3 pops on row 5.
    pix_ready = 1'b0;
    d0 = done_cnt;
    do_start(5'd5);
    step(10);
    exp_q.push_back({16'hA028, 1'b0});
    exp_q.push_back({16'hA029, 1'b0});
    exp_q.push_back({16'hA02A, 1'b0});
    pix_ready = 1'b1;
    step(3);
    pix_ready = 1'b0;
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_valid", {31'd0, pix_valid}, 32'd0);
    step(5);
    check("abort_no_done", done_cnt - d0, 32'd0);
    check("abort_popped3", exp_q.size(), 32'd0);

    // Abort and start together: abort wins.
    @(posedge clk); #1;
    start = 1'b1; row = 5'd2; abort = 1'b1;
    step(1);
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy", {31'd0, busy}, 32'd0);

    // Clean row 1 after abort.
    pix_ready = 1'b1;
    push_row(1);
    d0 = done_cnt;
    do_start(5'd1);
    wait_idle("row1", 60);
    check("row1_drained", exp_q.size(), 32'd0);
    check("row1_done", done_cnt - d0, 32'd1);

    // Asynchronous reset mid-fetch.
    pix_ready = 1'b0;
    do_start(5'd6);
    step(3);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_outs", {busy, done, err, rom_chipselect, pix_valid, pix_last}, 32'd0);
    check("async_rst_addr", {25'd0, rom_address}, 32'd0);
    step(2);
    @(negedge clk);
    reset_n = 1'b1;
    pix_ready = 1'b1;
    push_row(2);
    d0 = done_cnt;
    do_start(5'd2);
    wait_idle("row2", 60);
    check("row2_drained", exp_q.size(), 32'd0);
    check("row2_done", done_cnt - d0, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
